req_arbiter7: RTL and testbench
===============================

Name: req_arbiter7

Overview:
- Sequences seven requesters onto one shared resource, e.g. a shared tri-state bus or output port.
- Each cycle it either holds the current owner or picks the next owner using the team's 7-input priority encoding.
- It drives a registered one-hot grant plus an encoded owner ID: line k reports k+1, and 0 means no owner.
- It sits between the requester blocks and the resource's output-enable and select logic.

Parameters:
- RR, 0: arbitration mode. 0 = fixed priority, req[6] highest and req[0] lowest. 1 = round-robin.
- MAX_HOLD, 15: maximum consecutive cycles one grant may stay asserted. Range 0..255. 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  7  request lines; req[k] = 1 means requester k wants the resource.
- done  input  1  owner's end-of-transfer strobe; sampled only in GRANT.
- grant  output  7  registered one-hot grant; all zero when nobody owns the resource.
- grant_id  output  3  encoded owner: k+1 when grant[k] = 1, otherwise 0.
- busy  output  1  1 exactly while the state is GRANT.
- timeout  output  1  one-cycle pulse, high in the GAP cycle that follows a timeout release.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset:
  - On a rising edge with reset = 1, the next state is IDLE.
  - grant = 0, grant_id = 0, busy = 0, timeout = 0.
  - Hold counter = 0, round-robin pointer ptr = 0.
  - Reset has priority over every other event, including mid-GRANT: the grant drops at that same edge.
- States:
  - IDLE: no owner. Arbitrates every cycle.
  - GRANT: one owner g; grant[g] = 1.
  - GAP: mandatory one-cycle turnaround, grant = 0. Arbitrates exactly like IDLE.
- Arbitration (in IDLE or GAP, when any req bit is 1):
  - Winner w is latched at the next edge and the state goes to GRANT.
  - Latency is one cycle from the sampled request to grant[w] = 1.
  - If no req bit is set: IDLE stays IDLE, and GAP goes to IDLE.
- Winner selection, fixed priority (RR = 0):
  - The highest set index wins.
  - Encoding: req[6] gives grant_id = 7, req[5] gives 6, and so on down to req[0] giving 1.
- Winner selection, round-robin (RR = 1):
  - Search order is ptr-1, ptr-2, ..., wrapping from 0 to 6, with ptr itself checked last.
  - Because ptr = 0 after reset, the first search order is 6, 5, ..., 0, identical to fixed priority.
  - ptr is loaded with w on every entry to GRANT.
- GRANT hold and release:
  - The hold counter clears to 0 on entry and increments every cycle spent in GRANT.
  - Release occurs when any of these is true in a GRANT cycle: done = 1; req[g] = 0; MAX_HOLD != 0 and counter = MAX_HOLD-1.
  - After a timeout release, grant has been high exactly MAX_HOLD cycles.
  - On release, the next state is GAP with grant = 0 and grant_id = 0.
- timeout pulse:
  - timeout = 1 in the GAP cycle only when the release was caused solely by the counter.
  - If done or req[g] = 0 coincides with the counter limit, timeout = 0.
- No preemption:
  - Higher-priority requests arriving during GRANT are ignored until GAP.
  - Changes on non-owner req lines never affect the grant.
- Back-to-back ownership: the same requester may win again in GAP, e.g. if it is the only requester. The GAP cycle is never skipped.
- Invariants:
  - grant is always one-hot or zero.
  - grant_id is consistent with grant in every cycle.
  - busy = (grant != 0).
  - The counter saturates and never wraps; its width is 8 bits.

Test Plan:
1. Reset priority: assert reset with req = 7'h7F; hold it through a cycle in GRANT -> grant = 0, grant_id = 0, busy = 0 on the next edge; after reset releases, grant = 7'h40, grant_id = 7.
2. Fixed priority: RR = 0, req = 7'b0010110 held -> one cycle later grant = 7'b0010000, grant_id = 5. Pulse done -> one GAP cycle with grant = 0, then grant_id = 5 again.
3. Release by req drop: RR = 0, req = 7'b0000011, then drop req[1] after 3 grant cycles -> GAP for 1 cycle, then grant = 7'b0000001, grant_id = 1.
4. Timeout: MAX_HOLD = 4, req = 7'b0000100 held, done = 0 -> grant high exactly 4 cycles; timeout = 1 only in the following GAP cycle; re-grant grant_id = 3 on the next cycle.
5. Round-robin: RR = 1, req = 7'h7F held, done pulsed every grant -> grant_id sequence 7, 6, 5, 4, 3, 2, 1, 7, with one GAP cycle between each.
6. No preemption and done/timeout coincidence: owner grant_id = 2 when req[6] rises -> grant unchanged until release. Then MAX_HOLD = 4 with done = 1 in cycle 4 -> GAP with timeout = 0.

Source files
------------

// File: rtl/req_arbiter7_if.sv
// Request/grant bundle between seven requesters and the shared-resource arbiter.
// The requester side drives req/done; the arbiter drives the grant and status outputs.
interface req_arbiter7_if;
    logic [6:0] req;
    logic       done;
    logic [6:0] grant;
    logic [2:0] grant_id;
    logic       busy;
    logic       timeout;

    modport master (output req, done, input grant, grant_id, busy, timeout);
    modport slave  (input req, done, output grant, grant_id, busy, timeout);
endinterface

// File: rtl/req_arbiter7.sv
// Seven-way arbiter for one shared resource: fixed-priority or round-robin pick,
// registered one-hot grant, hold timeout and a mandatory one-cycle gap between owners.
module req_arbiter7 #(
    parameter int RR       = 0,
    parameter int MAX_HOLD = 15
) (
    input  logic          clk,
    input  logic          reset,
    req_arbiter7_if.slave bus
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

    localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;      // last winner; doubles as the current owner index
    logic [7:0] hold_q, hold_d;
    logic [6:0] grant_q, grant_d;
    logic [2:0] id_q, id_d;
    logic       timeout_q, timeout_d;
    logic [2:0] win;
    logic       owner_req;
    logic       hit_limit;

    // Round-robin scans ptr-1 down to ptr (wrapping); the last match is the highest priority.
    function automatic logic [2:0] pick(input logic [6:0] req, input logic [2:0] ptr);
        logic [2:0] w;
        int         idx;
        w = '0;
        if (RR == 0) begin
            for (int k = 0; k < 7; k++)
                if (req[k]) w = 3'(k);
        end else begin
            for (int i = 7; i >= 1; i--) begin
                idx = int'(ptr) - i;
                if (idx < 0) idx = idx + 7;
                if (req[idx[2:0]]) w = idx[2:0];
            end
        end
        return w;
    endfunction

    assign win       = pick(bus.req, ptr_q);
    assign owner_req = bus.req[ptr_q];
    assign hit_limit = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        id_d      = id_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                if (|bus.req) begin
                    state_d = GRANT;
                    ptr_d   = win;
                    hold_d  = 8'd0;
                    grant_d = 7'(1) << win;
                    id_d    = win + 3'd1;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    id_d    = '0;
                end
            end
            GRANT: begin
                hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
                if (bus.done || !owner_req || hit_limit) begin
                    state_d   = GAP;
                    grant_d   = '0;
                    id_d      = '0;
                    timeout_d = hit_limit && !bus.done && owner_req;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                id_d    = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            grant_q   <= '0;
            id_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.grant_id = id_q;
    assign bus.busy     = (state_q == GRANT);
    assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_req_arbiter7.sv
// Bench for req_arbiter7: a fixed-priority instance (MAX_HOLD=4) and a round-robin instance
// (MAX_HOLD=15) share clock and reset; each vector's expected outputs pass through a scoreboard queue.
module tb_req_arbiter7;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    req_arbiter7_if fp_if ();
    req_arbiter7_if rr_if ();

    req_arbiter7 #(.RR(0), .MAX_HOLD(4)) u_fp (
        .clk   (clk),
        .reset (reset),
        .bus   (fp_if)
    );

    req_arbiter7 #(.RR(1), .MAX_HOLD(15)) u_rr (
        .clk   (clk),
        .reset (reset),
        .bus   (rr_if)
    );

    typedef struct {
        string      name;
        bit         use_rr;
        logic       rst;
        logic [6:0] req;
        logic       done;
        logic [6:0] gnt;
        logic [2:0] id;
        logic       busy;
        logic       to;
    } vec_t;

    typedef struct packed {
        logic [6:0] gnt;
        logic [2:0] id;
        logic       busy;
        logic       to;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input string name, input bit use_rr, input logic rst,
                                input logic [6:0] req, input logic done, input logic [6:0] gnt,
                                input logic [2:0] id, input logic busy, input logic to);
        vec_t v;
        v.name = name; v.use_rr = use_rr; v.rst = rst; v.req = req; v.done = done;
        v.gnt = gnt; v.id = id; v.busy = busy; v.to = to;
        return v;
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got grant=%b id=%0d busy=%b timeout=%b, expected grant=%b id=%0d busy=%b timeout=%b",
                     name, act.gnt, act.id, act.busy, act.to, exp.gnt, exp.id, exp.busy, exp.to);
        end
    endtask

    // Drive one cycle of inputs at negedge, sample #1 after the following posedge.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset      = v.rst;
        fp_if.req  = v.use_rr ? 7'h00 : v.req;
        fp_if.done = v.use_rr ? 1'b0  : v.done;
        rr_if.req  = v.use_rr ? v.req  : 7'h00;
        rr_if.done = v.use_rr ? v.done : 1'b0;
        sb_q.push_back('{v.gnt, v.id, v.busy, v.to});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, expected one pending entry", v.name);
        end else begin
            e = sb_q.pop_front();
            if (v.use_rr) got = '{rr_if.grant, rr_if.grant_id, rr_if.busy, rr_if.timeout};
            else          got = '{fp_if.grant, fp_if.grant_id, fp_if.busy, fp_if.timeout};
            check(v.name, got, e);
        end
    endtask

    initial begin
        reset      = 1'b1;
        fp_if.req  = '0;
        fp_if.done = 1'b0;
        rr_if.req  = '0;
        rr_if.done = 1'b0;

        // Reset priority, including a reset landing mid-GRANT.
        tbl.push_back(mk("rst_hold",     0, 1, 7'h7F, 0, 7'h00, 0, 0, 0));
        tbl.push_back(mk("rst_rel",      0, 0, 7'h7F, 0, 7'h40, 7, 1, 0));
        tbl.push_back(mk("rst_midgrant", 0, 1, 7'h7F, 0, 7'h00, 0, 0, 0));
        tbl.push_back(mk("rst_still",    0, 1, 7'h7F, 0, 7'h00, 0, 0, 0));
        tbl.push_back(mk("rst_regrant",  0, 0, 7'h7F, 0, 7'h40, 7, 1, 0));
        tbl.push_back(mk("rst_clean",    0, 1, 7'h00, 0, 7'h00, 0, 0, 0));
        // Fixed priority, release by done.
        tbl.push_back(mk("fp_pick5",     0, 0, 7'h16, 0, 7'h10, 5, 1, 0));
        tbl.push_back(mk("fp_done_gap",  0, 0, 7'h16, 1, 7'h00, 0, 0, 0));
        tbl.push_back(mk("fp_again5",    0, 0, 7'h16, 0, 7'h10, 5, 1, 0));
        tbl.push_back(mk("fp_drop_gap",  0, 0, 7'h00, 0, 7'h00, 0, 0, 0));
        tbl.push_back(mk("fp_idle",      0, 0, 7'h00, 0, 7'h00, 0, 0, 0));
        // Release by the owner dropping its request after three grant cycles.
        tbl.push_back(mk("drop_g1",      0, 0, 7'h03, 0, 7'h02, 2, 1, 0));
        tbl.push_back(mk("drop_g2",      0, 0, 7'h03, 0, 7'h02, 2, 1, 0));
        tbl.push_back(mk("drop_g3",      0, 0, 7'h03, 0, 7'h02, 2, 1, 0));
        tbl.push_back(mk("drop_gap",     0, 0, 7'h01, 0, 7'h00, 0, 0, 0));
        tbl.push_back(mk("drop_next1",   0, 0, 7'h01, 0, 7'h01, 1, 1, 0));
        tbl.push_back(mk("drop_gap2",    0, 0, 7'h00, 0, 7'h00, 0, 0, 0));
        tbl.push_back(mk("drop_idle",    0, 0, 7'h00, 0, 7'h00, 0, 0, 0));
        // Round-robin rotation with done every grant, then a back-to-back re-win of ptr itself.
        tbl.push_back(mk("rr_7",         1, 0, 7'h7F, 0, 7'h40, 7, 1, 0));
        for (int k = 5; k >= 0; k--) begin
            tbl.push_back(mk("rr_gap",   1, 0, 7'h7F, 1, 7'h00, 0, 0, 0));
            tbl.push_back(mk($sformatf("rr_%0d", k + 1), 1, 0, 7'h7F, 0, 7'(1) << k, 3'(k + 1), 1, 0));
        end
        tbl.push_back(mk("rr_gap",       1, 0, 7'h7F, 1, 7'h00, 0, 0, 0));
        tbl.push_back(mk("rr_wrap7",     1, 0, 7'h7F, 0, 7'h40, 7, 1, 0));
        tbl.push_back(mk("rr_gap_solo",  1, 0, 7'h40, 1, 7'h00, 0, 0, 0));
        tbl.push_back(mk("rr_solo7",     1, 0, 7'h40, 0, 7'h40, 7, 1, 0));
        tbl.push_back(mk("rr_end_gap",   1, 0, 7'h00, 0, 7'h00, 0, 0, 0));
        tbl.push_back(mk("rr_end_idle",  1, 0, 7'h00, 0, 7'h00, 0, 0, 0));

        foreach (tbl[i]) step(tbl[i]);

        // Timeout: grant high exactly MAX_HOLD=4 cycles, pulse only in the gap, immediate re-grant.
        for (int c = 1; c <= 4; c++)
            step(mk($sformatf("to_hold%0d", c), 0, 0, 7'h04, 0, 7'h04, 3, 1, 0));
        step(mk("to_gap_pulse",  0, 0, 7'h04, 0, 7'h00, 0, 0, 1));
        step(mk("to_regrant",    0, 0, 7'h04, 0, 7'h04, 3, 1, 0));
        // Done coinciding with the hold limit: release without a timeout pulse.
        for (int c = 2; c <= 4; c++)
            step(mk($sformatf("co_hold%0d", c), 0, 0, 7'h04, 0, 7'h04, 3, 1, 0));
        step(mk("co_done_gap",   0, 0, 7'h04, 1, 7'h00, 0, 0, 0));
        step(mk("co_idle",       0, 0, 7'h00, 0, 7'h00, 0, 0, 0));
        // Request drop coinciding with the hold limit: also no timeout pulse.
        step(mk("cd_g1",         0, 0, 7'h08, 0, 7'h08, 4, 1, 0));
        step(mk("cd_g2",         0, 0, 7'h08, 0, 7'h08, 4, 1, 0));
        step(mk("cd_g3",         0, 0, 7'h08, 0, 7'h08, 4, 1, 0));
        step(mk("cd_g4",         0, 0, 7'h08, 0, 7'h08, 4, 1, 0));
        step(mk("cd_drop_gap",   0, 0, 7'h00, 0, 7'h00, 0, 0, 0));
        step(mk("cd_idle",       0, 0, 7'h00, 0, 7'h00, 0, 0, 0));
        // No preemption: higher and other requests appear while requester 1 owns the resource.
        step(mk("np_own2",       0, 0, 7'h02, 0, 7'h02, 2, 1, 0));
        step(mk("np_req6",       0, 0, 7'h42, 0, 7'h02, 2, 1, 0));
        step(mk("np_noise",      0, 0, 7'h5B, 0, 7'h02, 2, 1, 0));
        step(mk("np_done_gap",   0, 0, 7'h42, 1, 7'h00, 0, 0, 0));
        step(mk("np_win7",       0, 0, 7'h42, 0, 7'h40, 7, 1, 0));
        step(mk("np_gap",        0, 0, 7'h00, 0, 7'h00, 0, 0, 0));
        step(mk("np_idle",       0, 0, 7'h00, 0, 7'h00, 0, 0, 0));

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain: got %0d pending entries, expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
